// File: rtl/bdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bdram_arbiter
//  Purpose  : Two-requester front end for a single-port 32-bit block RAM
//             (byte write enables, one-cycle read latency). Merges the CPU
//             instruction-fetch and data ports onto the one RAM port, routes
//             the returned word to the winner with a valid pulse, and keeps a
//             held copy of each requester's last returned word.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             inst_req/addr/gnt     - instruction read request, grant
//             inst_rvalid/rdata     - instruction response pulse and data
//             data_req/we/addr/wdata- data request (we == 0 means read)
//             data_gnt              - data grant
//             data_rvalid/rdata     - data response pulse and data
//             bram_ena/wea/addra/dina/douta - block RAM port
//  Revision : 1.0 - initial release
// ============================================================================
module bdram_arbiter #(
    parameter int ADDR_LSB   = 2,
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_gnt,
    output logic          inst_rvalid,
    output logic [31:0]   inst_rdata,

    input  logic          data_req,
    input  logic [3:0]    data_we,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [31:0]   data_rdata,

    output logic          bram_ena,
    output logic [3:0]    bram_wea,
    output logic [AW-1:0] bram_addra,
    output logic [31:0]   bram_dina,
    input  logic [31:0]   bram_douta
);

    localparam int c_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    logic [c_SW-1:0] r_starve_cnt;
    logic [1:0]      r_resp_own;      // {inst, data} grants of the previous cycle
    logic [31:0]     r_inst_hold;
    logic [31:0]     r_data_hold;

    logic            w_starved;
    logic            w_inst_gnt;
    logic            w_data_gnt;
    logic [31:0]     w_win_addr;
    logic            w_inst_rvalid;
    logic            w_data_rvalid;
    logic            w_unused;

    // Data has priority unless instruction fetch has waited STARVE_MAX cycles.
    // Nothing is granted while reset is held.
    assign w_starved  = (r_starve_cnt == c_STARVE_MAX);
    assign w_inst_gnt = ~rst & inst_req & (~data_req | w_starved);
    assign w_data_gnt = ~rst & data_req & ~(inst_req & w_starved);

    assign inst_gnt   = w_inst_gnt;
    assign data_gnt   = w_data_gnt;

    // Idle cycles drive address/data from the data port.
    assign w_win_addr = w_inst_gnt ? inst_addr : data_addr;
    assign bram_ena   = w_inst_gnt | w_data_gnt;
    assign bram_wea   = w_data_gnt ? data_we : 4'b0000;
    assign bram_addra = w_win_addr[ADDR_LSB+AW-1:ADDR_LSB];
    assign bram_dina  = data_wdata;

    // Upper address bits alias onto the RAM; they are intentionally unused.
    assign w_unused   = ^{inst_addr, data_addr};

    // Gating with rst suppresses the response of an access granted just
    // before reset rose; the owner register only clears at the reset edge.
    assign w_inst_rvalid = r_resp_own[1] & ~rst;
    assign w_data_rvalid = r_resp_own[0] & ~rst;

    assign inst_rvalid = w_inst_rvalid;
    assign data_rvalid = w_data_rvalid;

    // Live RAM data during the valid cycle, held copy afterwards.
    assign inst_rdata  = w_inst_rvalid ? bram_douta : r_inst_hold;
    assign data_rdata  = w_data_rvalid ? bram_douta : r_data_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_own <= 2'b00;
        end else begin
            r_resp_own <= {w_inst_gnt, w_data_gnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_inst_gnt) begin
            r_starve_cnt <= '0;
        end else if (inst_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Hold registers capture the RAM word at the edge that ends the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_hold <= 32'h0;
            r_data_hold <= 32'h0;
        end else begin
            if (r_resp_own[1]) begin
                r_inst_hold <= bram_douta;
            end
            if (r_resp_own[0]) begin
                r_data_hold <= bram_douta;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bdram_arbiter
//  Purpose  : Self-checking bench for bdram_arbiter with a behavioural block
//             RAM (write echoes input) and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bdram_arbiter;

    localparam int AW         = 16;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic [3:0]    data_we;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          bram_ena;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [31:0]   bram_douta;

    always #5 clk = ~clk;

    bdram_arbiter #(
        .ADDR_LSB   (2),
        .AW         (AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .bram_ena    (bram_ena),
        .bram_wea    (bram_wea),
        .bram_addra  (bram_addra),
        .bram_dina   (bram_dina),
        .bram_douta  (bram_douta)
    );

    // Behavioural block RAM: one-cycle read, write echoes its input word.
    logic [31:0] ram     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bram_ena) begin
            if (|bram_wea) begin
                for (int b = 0; b < 4; b++) begin
                    if (bram_wea[b]) ram[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
                end
                bram_douta <= bram_dina;
            end else begin
                bram_douta <= ram[bram_addra];
            end
        end
    end

    typedef struct {
        string       name;
        bit          r;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        logic [3:0]  dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          eig;
        bit          edg;
    } vec_t;

    typedef struct {
        bit          own_inst;
        logic [31:0] data;
    } resp_t;

    vec_t  tbl[$];
    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic [31:0] last_inst;
    logic [31:0] last_data;

    function automatic vec_t mk(string nm, bit r, bit ir, logic [31:0] ia,
                                bit dr, logic [3:0] dwe, logic [31:0] da,
                                logic [31:0] dwd, bit eig, bit edg);
        vec_t v;
        v.name = nm; v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe;
        v.da = da; v.dwd = dwd; v.eig = eig; v.edg = edg;
        return v;
    endfunction

    function automatic logic [15:0] widx(logic [31:0] a);
        return a[17:2];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Applies one vector for one cycle; called just after a falling edge.
    task automatic apply(vec_t v);
        resp_t r;
        bit    exp_iv;
        bit    exp_dv;
        logic [15:0] w;
        rst        = v.r;
        inst_req   = v.ir;
        inst_addr  = v.ia;
        data_req   = v.dr;
        data_we    = v.dwe;
        data_addr  = v.da;
        data_wdata = v.dwd;
        #1;
        exp_iv = !v.r && sb.size() > 0 && sb[0].own_inst;
        exp_dv = !v.r && sb.size() > 0 && !sb[0].own_inst;
        chk({v.name, " inst_rvalid"}, 32'(inst_rvalid), 32'(exp_iv));
        chk({v.name, " data_rvalid"}, 32'(data_rvalid), 32'(exp_dv));
        if (v.r) begin
            sb.delete();
            chk({v.name, " inst_rdata"}, inst_rdata, last_inst);
            chk({v.name, " data_rdata"}, data_rdata, last_data);
        end else if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.own_inst) begin
                chk({v.name, " inst_rdata"}, inst_rdata, r.data);
                chk({v.name, " data_rdata held"}, data_rdata, last_data);
                last_inst = r.data;
            end else begin
                chk({v.name, " data_rdata"}, data_rdata, r.data);
                chk({v.name, " inst_rdata held"}, inst_rdata, last_inst);
                last_data = r.data;
            end
        end else begin
            chk({v.name, " inst_rdata held"}, inst_rdata, last_inst);
            chk({v.name, " data_rdata held"}, data_rdata, last_data);
        end
        chk({v.name, " inst_gnt"}, 32'(inst_gnt), 32'(v.eig));
        chk({v.name, " data_gnt"}, 32'(data_gnt), 32'(v.edg));
        chk({v.name, " bram_ena"}, 32'(bram_ena), 32'(v.eig | v.edg));
        if (v.eig) begin
            w = widx(v.ia);
            chk({v.name, " bram_addra"}, 32'(bram_addra), 32'(w));
            chk({v.name, " bram_wea"}, 32'(bram_wea), 32'h0);
            sb.push_back('{1'b1, ref_mem[w]});
        end else if (v.edg) begin
            w = widx(v.da);
            chk({v.name, " bram_addra"}, 32'(bram_addra), 32'(w));
            chk({v.name, " bram_wea"}, 32'(bram_wea), 32'(v.dwe));
            if (v.dwe != 4'h0) begin
                sb.push_back('{1'b0, v.dwd});
                for (int b = 0; b < 4; b++) begin
                    if (v.dwe[b]) ref_mem[w][8*b +: 8] = v.dwd[8*b +: 8];
                end
            end else begin
                sb.push_back('{1'b0, ref_mem[w]});
            end
        end else begin
            chk({v.name, " bram_wea idle"}, 32'(bram_wea), 32'h0);
        end
        @(negedge clk);
        if (v.r) begin
            last_inst = 32'h0;
            last_data = 32'h0;
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
        data_we = '0; data_addr = '0; data_wdata = '0;
        last_inst = 32'h0; last_data = 32'h0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     <= 32'h5A00_0000 ^ (i * 32'h0001_0003);
            ref_mem[i]  = 32'h5A00_0000 ^ (i * 32'h0001_0003);
        end
        ram[16'h0010] <= 32'hDEAD_BEEF; ref_mem[16'h0010] = 32'hDEAD_BEEF;
        ram[16'h0003] <= 32'h1122_3344; ref_mem[16'h0003] = 32'h1122_3344;
        @(negedge clk);

        //           name         rst ir  ia            dr dwe    da     dwd           ig dg
        tbl.push_back(mk("rst_req",  1, 1, 32'h40,       1, 4'h0, 32'h8, 32'h0,        0, 0));
        tbl.push_back(mk("idle0",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));
        tbl.push_back(mk("iread40",  0, 1, 32'h40,       0, 4'h0, 32'h0, 32'h0,        1, 0));
        tbl.push_back(mk("idle1",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));
        tbl.push_back(mk("idle2",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));
        tbl.push_back(mk("dwrite",   0, 0, 32'h0,        1, 4'h2, 32'hC, 32'hAABBCCDD, 0, 1));
        tbl.push_back(mk("dread",    0, 0, 32'h0,        1, 4'h0, 32'hC, 32'h0,        0, 1));
        tbl.push_back(mk("idle3",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));
        tbl.push_back(mk("ib2b0",    0, 1, 32'h0,        0, 4'h0, 32'h0, 32'h0,        1, 0));
        tbl.push_back(mk("ib2b1",    0, 1, 32'h4,        0, 4'h0, 32'h0, 32'h0,        1, 0));
        tbl.push_back(mk("ib2b2",    0, 1, 32'h8,        0, 4'h0, 32'h0, 32'h0,        1, 0));
        tbl.push_back(mk("iwrap",    0, 1, 32'h00040004, 0, 4'h0, 32'h0, 32'h0,        1, 0));
        tbl.push_back(mk("idle4",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));
        // Contention: data wins four times, then the starvation guard lets inst in.
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk("both", 0, 1, 32'h40, 1, 4'h0, 32'h8, 32'h0,
                             (k % 5) == 4, (k % 5) != 4));
        end
        tbl.push_back(mk("idle5",    0, 0, 32'h0,        0, 4'h0, 32'h0, 32'h0,        0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-flight: counter built up to 3, data read granted, then reset.
        for (int k = 0; k < 3; k++)
            apply(mk("pre_both", 0, 1, 32'h40, 1, 4'h0, 32'h8, 32'h0, 0, 1));
        apply(mk("dread_N",  0, 0, 32'h0,  1, 4'h0, 32'h40, 32'h0, 0, 1));
        apply(mk("rst_N1",   1, 1, 32'h40, 1, 4'h0, 32'h40, 32'h0, 0, 0));
        // A cleared counter means four data grants before inst again.
        for (int k = 0; k < 5; k++)
            apply(mk("post_both", 0, 1, 32'h40, 1, 4'h0, 32'h8, 32'h0, k == 4, k != 4));
        apply(mk("idle6",    0, 0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0));
        // Held instruction request across reset is granted in the first free cycle.
        apply(mk("rst_ihold", 1, 1, 32'h10, 0, 4'h0, 32'h0, 32'h0, 0, 0));
        apply(mk("rel_ihold", 0, 1, 32'h10, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        apply(mk("idle7",    0, 0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0));
        apply(mk("idle8",    0, 0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
